// File: rtl/bus_pkg.sv
// Shared definitions for the system-bus interface switch.
//   BUS_W            : default bus vector width (48)
//   BIT_* / *_HI/_LO : bit positions of the bus fields, MSB first:
//                      pa,cl,w,r,s,f,in,ok,en,pe,qb,pn,nb[4],ad[16],dt[16]
//   ST_*             : arbiter FSM state encodings
//   strobe_of        : any transfer strobe (w,r,s,f,in) set in a vector
//   resp_of          : any slave response (ok,en,pe) set in a vector
package bus_pkg;

   localparam int unsigned BUS_W = 48;

   localparam int unsigned BIT_PA = 47;
   localparam int unsigned BIT_CL = 46;
   localparam int unsigned BIT_W  = 45;
   localparam int unsigned BIT_R  = 44;
   localparam int unsigned BIT_S  = 43;
   localparam int unsigned BIT_F  = 42;
   localparam int unsigned BIT_IN = 41;
   localparam int unsigned BIT_OK = 40;
   localparam int unsigned BIT_EN = 39;
   localparam int unsigned BIT_PE = 38;
   localparam int unsigned BIT_QB = 37;
   localparam int unsigned BIT_PN = 36;
   localparam int unsigned NB_HI  = 35;
   localparam int unsigned NB_LO  = 32;
   localparam int unsigned AD_HI  = 31;
   localparam int unsigned AD_LO  = 16;
   localparam int unsigned DT_HI  = 15;
   localparam int unsigned DT_LO  = 0;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_GRANT   = 2'd1;
   localparam logic [1:0] ST_HOLD    = 2'd2;
   localparam logic [1:0] ST_RELEASE = 2'd3;

   function automatic logic strobe_of(input logic [BUS_W-1:0] v);
      return v[BIT_W] | v[BIT_R] | v[BIT_S] | v[BIT_F] | v[BIT_IN];
   endfunction

   function automatic logic resp_of(input logic [BUS_W-1:0] v);
      return v[BIT_OK] | v[BIT_EN] | v[BIT_PE];
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational bus-request picker.
//   req   : request vector, one bit per master
//   last  : index of the previous owner (round-robin reference point)
//   rr    : 1 = round-robin starting after last, 0 = fixed priority (index 0 highest)
//   idx   : chosen master index (0 when nothing is requested)
//   valid : at least one request present
module rr_pick #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   input  logic          rr,
   output logic [IW-1:0] idx,
   output logic          valid
);
   import bus_pkg::*;

   logic [IW-1:0] cand;

   always_comb begin
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      if (rr) begin
         // Scan offsets from farthest to nearest so the nearest requester after
         // last is the final (winning) assignment.
         for (int unsigned k = N; k >= 1; k--) begin
            cand = IW'((32'(last) + k) % N);
            if (req[cand]) begin
               idx   = cand;
               valid = 1'b1;
            end
         end
      end else begin
         for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
               idx   = IW'(i);
               valid = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/isk_n.sv
// System-bus interface switch: arbitrates MASTERS bus masters for one shared
// system bus using the zg/zw/zz reservation handshake and routes vectors.
//   clk_sys   : system clock
//   reset     : synchronous, active-high
//   zg        : bus request per master
//   zw        : bus grant per master (one-hot or zero, registered)
//   zz        : bus held by another master (registered)
//   md        : master drive vectors, port i at [i*BUS_W +: BUS_W]
//   mr        : per-master receive vectors (slave drive OR routed bus)
//   sd        : slave drive vector
//   sr        : slave receive vector (owner's drive, cl ORed from all masters)
//   no_answer : one-cycle pulse per master when a strobe goes unanswered
module isk_n #(
   parameter int unsigned MASTERS = 4,
   parameter int unsigned BUS_W   = 48,
   parameter bit          RR      = 1'b1,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                     clk_sys,
   input  logic                     reset,
   input  logic [MASTERS-1:0]       zg,
   output logic [MASTERS-1:0]       zw,
   output logic [MASTERS-1:0]       zz,
   input  logic [MASTERS*BUS_W-1:0] md,
   output logic [MASTERS*BUS_W-1:0] mr,
   input  logic [BUS_W-1:0]         sd,
   output logic [BUS_W-1:0]         sr,
   output logic [MASTERS-1:0]       no_answer
);
   import bus_pkg::*;

   localparam int unsigned   IW       = (MASTERS > 1) ? $clog2(MASTERS) : 1;
   localparam logic [15:0]   TMO      = 16'(TIMEOUT);
   localparam logic [IW-1:0] LAST_RST = IW'(MASTERS - 1);

   logic [1:0]         state_q, state_d;
   logic [IW-1:0]      owner_q, owner_d;
   logic [IW-1:0]      last_q, last_d;
   logic [MASTERS-1:0] zw_q, zw_d;
   logic [MASTERS-1:0] zz_q, zz_d;
   logic [MASTERS-1:0] na_q, na_d;
   logic [15:0]        tmr_q, tmr_d;
   logic               run_q, run_d;
   logic               stb_q, stb_d;

   logic [IW-1:0]      pick_idx;
   logic               pick_valid;
   logic [MASTERS-1:0] owner_oh;
   logic [BUS_W-1:0]   owner_md;
   logic [BUS_W-1:0]   bus_all;
   logic               cl_any;
   logic               owner_req;
   logic               strobe;
   logic               resp;
   logic               fire;

   rr_pick #(
      .N  (MASTERS),
      .IW (IW)
   ) u_pick (
      .req   (zg),
      .last  (last_q),
      .rr    (RR),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // Owner decode, owner drive mux and the unarbitrated reset broadcast.
   always_comb begin
      owner_oh = '0;
      owner_md = '0;
      cl_any   = 1'b0;
      for (int i = 0; i < int'(MASTERS); i++) begin
         owner_oh[i] = (owner_q == IW'(i));
         if (owner_q == IW'(i)) begin
            owner_md = md[i*BUS_W +: BUS_W];
         end
         cl_any = cl_any | md[i*BUS_W + BIT_CL];
      end
   end

   assign owner_req = |(zg & owner_oh);
   assign strobe    = strobe_of(owner_md);
   assign resp      = resp_of(sd);

   // Arbitration FSM.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               owner_d = pick_idx;
               state_d = ST_GRANT;
            end
         end
         // A request dropped during GRANT still costs one HOLD cycle.
         ST_GRANT: state_d = ST_HOLD;
         ST_HOLD: begin
            if (!owner_req) begin
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            last_d  = owner_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // zw/zz are registered off GRANT/HOLD, so they rise entering HOLD and fall
   // entering IDLE: two cycles after zg rises from IDLE or drops in HOLD.
   always_comb begin
      zw_d = '0;
      zz_d = '0;
      if (state_q == ST_GRANT || state_q == ST_HOLD) begin
         zw_d = owner_oh;
         zz_d = ~owner_oh;
      end
   end

   // No-answer timer: starts on a strobe rising edge, a response clears it and
   // wins over a same-cycle strobe or expiry; after firing it idles until the
   // next strobe edge.
   always_comb begin
      tmr_d = tmr_q;
      run_d = run_q;
      fire  = 1'b0;
      stb_d = (state_q == ST_HOLD) && strobe;
      if (state_q != ST_HOLD || resp) begin
         tmr_d = '0;
         run_d = 1'b0;
      end else if (strobe && !stb_q) begin
         tmr_d = 16'd1;
         run_d = 1'b1;
         if (TMO == 16'd1) begin
            fire  = 1'b1;
            run_d = 1'b0;
         end
      end else if (run_q) begin
         if (tmr_q != 16'hffff) begin
            tmr_d = tmr_q + 16'd1;
         end
         if (tmr_d == TMO) begin
            fire  = 1'b1;
            run_d = 1'b0;
         end
      end
   end

   assign na_d = fire ? owner_oh : '0;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= ST_IDLE;
         owner_q <= LAST_RST;
         last_q  <= LAST_RST;
         zw_q    <= '0;
         zz_q    <= '0;
         na_q    <= '0;
         tmr_q   <= '0;
         run_q   <= 1'b0;
         stb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         zw_q    <= zw_d;
         zz_q    <= zz_d;
         na_q    <= na_d;
         tmr_q   <= tmr_d;
         run_q   <= run_d;
         stb_q   <= stb_d;
      end
   end

   // Slave-side routing.
   always_comb begin
      sr = '0;
      if (state_q == ST_GRANT || state_q == ST_HOLD) begin
         sr = owner_md;
      end
      sr[BIT_CL] = cl_any;
   end

   // Every master snoops the whole bus; only the owner sees slave responses.
   always_comb begin
      bus_all = sd | sr;
      mr      = '0;
      for (int i = 0; i < int'(MASTERS); i++) begin
         mr[i*BUS_W +: BUS_W] = bus_all;
         if (!owner_oh[i]) begin
            mr[i*BUS_W + BIT_OK] = 1'b0;
            mr[i*BUS_W + BIT_EN] = 1'b0;
            mr[i*BUS_W + BIT_PE] = 1'b0;
         end
      end
   end

   assign zw        = zw_q;
   assign zz        = zz_q;
   assign no_answer = na_q;

endmodule

// File: tb/tb_isk_n.sv
module tb_isk_n;
   localparam int M    = 4;
   localparam int BW   = 48;
   localparam int P_CL = 46;
   localparam int P_R  = 44;
   localparam int P_OK = 40;
   localparam int P_AD = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic [M-1:0]    zg_a, zw_a, zz_a, na_a;
   logic [M-1:0]    zg_b, zw_b, zz_b, na_b;
   logic [M*BW-1:0] md_a, mr_a, md_b, mr_b;
   logic [BW-1:0]   sd_a, sr_a, sd_b, sr_b;
   int              vecs = 0;
   int              errs = 0;

   always #5 clk = ~clk;

   isk_n #(.MASTERS(M), .BUS_W(BW), .RR(1'b1), .TIMEOUT(10)) dut_a (
      .clk_sys (clk), .reset (reset), .zg (zg_a), .zw (zw_a), .zz (zz_a),
      .md (md_a), .mr (mr_a), .sd (sd_a), .sr (sr_a), .no_answer (na_a)
   );

   isk_n #(.MASTERS(M), .BUS_W(BW), .RR(1'b0), .TIMEOUT(10)) dut_b (
      .clk_sys (clk), .reset (reset), .zg (zg_b), .zw (zw_b), .zz (zz_b),
      .md (md_b), .mr (mr_b), .sd (sd_b), .sr (sr_b), .no_answer (na_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [M*BW-1:0] put(input logic [M*BW-1:0] v, input int i,
                                           input logic [BW-1:0] x);
      logic [M*BW-1:0] mask;
      logic [M*BW-1:0] ext;
      mask = {{((M-1)*BW){1'b0}}, {BW{1'b1}}} << (i*BW);
      ext  = {{((M-1)*BW){1'b0}}, x} << (i*BW);
      return (v & ~mask) | ext;
   endfunction

   function automatic logic [BW-1:0] get(input logic [M*BW-1:0] v, input int i);
      return BW'(v >> (i*BW));
   endfunction

   // Bounded waits for a grant; an expired bound shows up as a zw miscompare.
   task automatic wait_a();
      for (int n = 0; n < 8 && zw_a == '0; n++) step();
   endtask

   task automatic wait_b();
      for (int n = 0; n < 8 && zw_b == '0; n++) step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before 100000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [BW-1:0] v;
      logic [BW-1:0] r;
      int            exp_o[5] = '{0, 1, 2, 3, 0};

      reset = 1'b1;
      zg_a  = '0; zg_b = '0;
      md_a  = '0; md_b = '0;
      sd_a  = '0; sd_b = '0;
      step(); step();
      reset = 1'b0;
      step();
      chk("rst_zw", zw_a, 4'b0000);
      chk("rst_zz", zz_a, 4'b0000);
      chk("rst_na", na_a, 4'b0000);
      chk("rst_sr", sr_a, 48'h0);

      // Single request from port 1
      v = '0;
      v[P_AD +: 16] = 16'h1234;
      md_a = put(md_a, 1, v);
      zg_a = 4'b0010;
      step();
      chk("lat_1cyc", zw_a, 4'b0000);
      step();
      chk("single_zw", zw_a, 4'b0010);
      chk("single_zz", zz_a, 4'b1101);
      chk("route_ad", sr_a[P_AD +: 16], 16'h1234);

      // Response masking and cl broadcast
      sd_a = '0;
      sd_a[P_OK] = 1'b1;
      #1;
      r = get(mr_a, 1); chk("ok_owner1", r[P_OK], 1'b1);
      r = get(mr_a, 0); chk("ok_mask0", r[P_OK], 1'b0);
      chk("snoop_ad0", r[P_AD +: 16], 16'h1234);
      r = get(mr_a, 2); chk("ok_mask2", r[P_OK], 1'b0);
      r = get(mr_a, 3); chk("ok_mask3", r[P_OK], 1'b0);
      sd_a = '0;
      r = '0;
      r[P_CL] = 1'b1;
      md_a = put(md_a, 3, r);
      #1;
      chk("cl_sr", sr_a[P_CL], 1'b1);
      r = get(mr_a, 0); chk("cl_mr0", r[P_CL], 1'b1);
      md_a = put(md_a, 3, 48'h0);

      // Timeout: r rises just after edge 0, pulse exactly after edge 10
      step();
      v[P_R] = 1'b1;
      md_a = put(md_a, 1, v);
      for (int k = 1; k <= 11; k++) begin
         step();
         chk("tmo_pulse", na_a, (k == 10) ? 4'b0010 : 4'b0000);
      end

      // ok during cycle 9 wins: no pulse, and no later pulse without a new edge
      v[P_R] = 1'b0;
      md_a = put(md_a, 1, v);
      step(); step();
      v[P_R] = 1'b1;
      md_a = put(md_a, 1, v);
      for (int k = 1; k <= 12; k++) begin
         step();
         sd_a = '0;
         if (k == 9) sd_a[P_OK] = 1'b1;
         chk("tmo_ok9", na_a, 4'b0000);
      end
      sd_a = '0;

      // Release: zw drops two edges after zg
      md_a = '0;
      zg_a = '0;
      step();
      chk("drop_zw1", zw_a, 4'b0010);
      step();
      chk("drop_zw2", zw_a, 4'b0000);
      chk("drop_zz2", zz_a, 4'b0000);

      // Round-robin fairness from reset
      reset = 1'b1;
      step();
      reset = 1'b0;
      zg_a = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         wait_a();
         chk("rr_grant", zw_a, 4'b0001 << exp_o[g]);
         chk("rr_zz", zz_a, ~(4'b0001 << exp_o[g]) & 4'b1111);
         if (g == 4) zg_a = '0;
         else zg_a[exp_o[g]] = 1'b0;
         step();
         if (g != 4) zg_a[exp_o[g]] = 1'b1;
         step();
         chk("rr_dead", zw_a, 4'b0000);
      end

      // Fixed priority on the second instance
      zg_b = 4'b1100;
      wait_b();
      chk("fp_first", zw_b, 4'b0100);
      zg_b[0] = 1'b1;
      step();
      chk("fp_held", zw_b, 4'b0100);
      zg_b[2] = 1'b0;
      step(); step();
      chk("fp_dead", zw_b, 4'b0000);
      wait_b();
      chk("fp_second", zw_b, 4'b0001);
      zg_b[0] = 1'b0;
      step(); step();
      wait_b();
      chk("fp_third", zw_b, 4'b1000);
      zg_b = '0;
      step(); step();
      chk("fp_idle", zw_b, 4'b0000);

      // Reset in the middle of a HOLD by port 2
      v = '0;
      v[P_AD +: 16] = 16'habcd;
      md_a = put(48'h0, 2, v);
      zg_a = 4'b0100;
      wait_a();
      chk("rh_zw", zw_a, 4'b0100);
      reset = 1'b1;
      zg_a  = 4'b0101;
      step();
      chk("rh_zw0", zw_a, 4'b0000);
      chk("rh_zz0", zz_a, 4'b0000);
      chk("rh_na0", na_a, 4'b0000);
      chk("rh_sr_idle", sr_a[P_AD +: 16], 16'h0000);
      reset = 1'b0;
      wait_a();
      chk("rh_regrant", zw_a, 4'b0001);
      zg_a = '0;
      step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/isk_n.md
# isk_n

Parametrised system-bus interface switch (successor to the fixed two-CPU/one-IO/one-memory switch). Arbitrates up to `MASTERS` bus masters (CPUs, I/O bus bridges) for one shared 48-bit system bus via the zg/zw/zz reservation handshake, routes the granted master's drive vector to all receivers and slave responses back, and flags transactions left unanswered. Sits at top level between the CPUs/IOBUS and the memory module.

## Interface
- `MASTERS`, 4: number of master ports (2..8).
- `BUS_W`, 48: bus vector width; bit layout pa,cl,w,r,s,f,in,ok,en,pe,qb,pn,nb[4],ad[16],dt[16].
- `RR`, 1: 1 = round-robin arbitration, 0 = fixed priority (port 0 highest).
- `TIMEOUT`, 255: cycles from strobe assertion to no-answer flag (1..65535).

Ports:
- `clk_sys` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `zg` in MASTERS: bus request, one per master.
- `zw` out MASTERS: bus grant, one-hot or zero.
- `zz` out MASTERS: bus held by another master.
- `md` in MASTERS*BUS_W: master drive vectors, port i at bits [i*BUS_W +: BUS_W].
- `mr` out MASTERS*BUS_W: per-master receive vectors.
- `sd` in BUS_W: slave (memory) drive vector.
- `sr` out BUS_W: slave receive vector.
- `no_answer` out MASTERS: one-cycle pulse, per master.

## Operation
- FSM states: IDLE, GRANT, HOLD, RELEASE.
- IDLE: if any zg set, pick winner (RR: first requester after last owner, wrapping MASTERS-1 -> 0; fixed: lowest index), register owner, -> GRANT.
- GRANT: zw[owner]=1, zz[j]=1 for all j != owner; -> HOLD.
- HOLD: owner's md routed. Timer starts on rising edge of any strobe (w,r,s,f,in) in owner's md; cleared on ok, en or pe from sd; on reaching TIMEOUT: no_answer[owner] pulse, timer stops until next strobe edge. Owner drops zg -> RELEASE.
- RELEASE: zw=0, zz=0, owner pointer updated for RR; -> IDLE. One dead cycle between owners, always.
- Routing: sr = md[owner] while GRANT/HOLD, else 0; sr[cl] = OR of cl over all md (reset broadcast never arbitrated). mr[i] = sd OR sr for every i (all masters see bus, including address/data for snooping); response bits ok/en/pe in mr[i] forced 0 for i != owner.
- Requests from non-owners during HOLD/RELEASE are held off, not lost; granted on next IDLE.
- zg[owner] dropped in GRANT: still passes through HOLD for one cycle then RELEASE.

## Timing
- Reset: state IDLE, owner pointer = MASTERS-1 (so RR first grant goes to port 0), zw=0, zz=0, no_answer=0, timer=0. Reset mid-transaction drops zw/zz next edge; no no_answer.
- zg->zw latency: 2 cycles from IDLE (registered). zg drop -> zw drop: 2 cycles.
- zw, zz, no_answer registered; sr, mr combinational from registered owner/state and inputs.
- Timer TIMEOUT counted in clk_sys cycles, 16-bit, saturating; strobe and response same cycle: response wins, no flag.

## Structure
- Shared package `bus_pkg`: bit-position localparams (PA..DT ranges), BUS_W, FSM state enum.
- Sub-module `rr_pick`: combinational round-robin/fixed-priority picker (req vector, last pointer, mode -> index, valid).

## Test plan
- Single request: reset, zg=4'b0010 -> zw=0010, zz=1101 two cycles later; md[1] address 16'h1234 appears on sr[ad].
- RR fairness: zg=1111 held, each master drops zg after one transaction -> grants in order 0,1,2,3,0 with one dead cycle between.
- Fixed priority (RR=0): zg=1100 then zg[0] raised during HOLD of port 2 -> next grant to port 0, then port 3.
- Timeout: TIMEOUT=10, owner raises r, sd silent -> no_answer[owner] pulses at cycle 10 exactly; ok at cycle 9 -> no pulse.
- Response masking: sd[ok]=1 during HOLD of port 1 -> mr[1][ok]=1, mr[0,2,3][ok]=0; cl from non-owner port 3 -> sr[cl]=1.
- Reset mid-HOLD: reset asserted with zw=0100 -> zw=0000, zz=0000 next edge, state IDLE, subsequent grant to port 0.
